// File: rtl/reg_file_status_pkg.sv
// Shared register-number and status-flag constants for the register file.
// Flag positions describe the {N,Z,V} status word.
package reg_file_status_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_LINK25 = 5'd25;
  localparam logic [4:0] REG_RA     = 5'd31;

  localparam int FLAG_N = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;
  localparam int FLAG_W = 3;

  typedef logic [4:0] reg_addr_t;

  function automatic logic commits(input logic we, input reg_addr_t addr);
    return we && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/reg_file_status_status_reg.sv
// {N,Z,V} status register: loads on flag_write, holds otherwise.
// Synchronous reset takes priority over a same-cycle load.
module status_reg
  import reg_file_status_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flag_write,
  input  logic [FLAG_W-1:0] flag_in,
  output logic [FLAG_W-1:0] status
);

  always_ff @(posedge clk) begin
    if (reset) begin
      status <= '0;
    end else if (flag_write) begin
      status[FLAG_N] <= flag_in[FLAG_N];
      status[FLAG_Z] <= flag_in[FLAG_Z];
      status[FLAG_V] <= flag_in[FLAG_V];
    end
  end

endmodule

// File: rtl/reg_file_status.sv
// 32-entry register file with combinational reads, optional write forwarding,
// a committed-write counter and a {N,Z,V} status register.
module reg_file_status
  import reg_file_status_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYPASS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        read_reg1,
  input  logic [4:0]        read_reg2,
  input  logic [4:0]        write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic [2:0]        flag_in,
  input  logic              flag_write,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] dbg_data,
  output logic [2:0]        status,
  output logic [31:0]       wr_count
);

  localparam bit FWD_EN = (BYPASS != 0);

  logic [DATA_W-1:0] regs [0:31];
  logic              commit;

  assign commit = commits(reg_write, write_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      wr_count <= '0;
    end else if (commit) begin
      regs[write_reg] <= write_data;
      wr_count        <= wr_count + 32'd1;
    end
  end

  // Entry 0 is never written, but reads still gate it so it is always zero.
  function automatic logic [DATA_W-1:0] lookup(input reg_addr_t addr, input logic fwd);
    if (addr == REG_ZERO)                   return '0;
    else if (fwd && commit && addr == write_reg) return write_data;
    else                                    return regs[addr];
  endfunction

  always_comb begin
    read_data1 = lookup(read_reg1, FWD_EN);
    read_data2 = lookup(read_reg2, FWD_EN);
    dbg_data   = lookup(dbg_addr, 1'b0);
  end

  status_reg u_status (
    .clk        (clk),
    .reset      (reset),
    .flag_write (flag_write),
    .flag_in    (flag_in),
    .status     (status)
  );

endmodule

// File: doc/reg_file_status.md
REG_FILE_STATUS -- requirements
Module: reg_file_status

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register and data width.
REQ-002 SHALL have parameter BYPASS, default 0: 1 forwards same-cycle write data to the read ports, 0 disables forwarding.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port read_reg1, input, 5, read port 1 address (instruction[25:21]).
REQ-006 SHALL have port read_reg2, input, 5, read port 2 address (instruction[20:16]).
REQ-007 SHALL have port write_reg, input, 5, destination address from the RegDest 4:1 select (rt, rd, $25, $31).
REQ-008 SHALL have port write_data, input, DATA_W, write-back value.
REQ-009 SHALL have port reg_write, input, 1, register write enable.
REQ-010 SHALL have port flag_in, input, 3, next status flags {N,Z,V} from the ALU.
REQ-011 SHALL have port flag_write, input, 1, status register write enable.
REQ-012 SHALL have port dbg_addr, input, 5, debug read address.
REQ-013 SHALL have port read_data1, output, DATA_W, read port 1 data.
REQ-014 SHALL have port read_data2, output, DATA_W, read port 2 data.
REQ-015 SHALL have port dbg_data, output, DATA_W, debug read data.
REQ-016 SHALL have port status, output, 3, registered flags {N,Z,V}.
REQ-017 SHALL have port wr_count, output, 32, count of committed register writes.

Function
REQ-018 SHALL hold 32 registers of DATA_W bits; register 0 SHALL always read 0.
REQ-019 SHALL make reads combinational, with zero-cycle latency from address to data on all three read ports.
REQ-020 SHALL commit write_data to regs[write_reg] at the rising clk edge when reg_write=1 and write_reg!=0.
REQ-021 SHALL ignore writes to register 0: no state change and no wr_count increment.
REQ-022 SHALL, with BYPASS=1, return write_data on a read port whose address equals write_reg while reg_write=1 and write_reg!=0; the debug port is never bypassed.
REQ-023 SHALL, with BYPASS=0, return the pre-edge register value during a same-cycle read/write to the same address.
REQ-024 SHALL load status from flag_in at the rising edge when flag_write=1, and hold status otherwise.
REQ-025 SHALL perform reg_write and flag_write in the same cycle independently.
REQ-026 SHALL increment wr_count by 1 per committed write, wrapping 0xFFFFFFFF -> 0.
REQ-027 SHALL allow write_reg 25 and 31 (link writes for bgezal, baln, jmxor) with no special casing beyond REQ-020.

Reset
REQ-028 SHALL, at a rising edge with reset=1, clear all registers, status and wr_count to 0.
REQ-029 SHALL give reset priority over a same-cycle reg_write or flag_write, which are dropped.
REQ-030 SHALL leave read ports combinational during reset, so they show 0 after the reset edge.

Structure
REQ-031 SHALL take register-number constants (REG_ZERO=0, REG_LINK25=25, REG_RA=31) and flag bit positions (N=2, Z=1, V=0) from a shared constants include.
REQ-032 SHALL implement the status register as sub-module status_reg (clk, reset, flag_write, flag_in, status).

Verification
REQ-033 Bench SHALL check: reset, then write 0xDEADBEEF to $5, next cycle read_reg1=5 -> read_data1=0xDEADBEEF, wr_count=1.
REQ-034 Bench SHALL check: write 0x12345678 to $0 -> read_data1=0 for read_reg1=0, wr_count unchanged.
REQ-035 Bench SHALL check: BYPASS=1, write 0xA5A5A5A5 to $31 with read_reg2=31 the same cycle -> read_data2=0xA5A5A5A5 before the edge; with BYPASS=0 -> old value.
REQ-036 Bench SHALL check: flag_write=1, flag_in=3'b101, plus a write to $25 the same cycle -> status=3'b101 and $25 updated; flag_write=0 next cycle -> status held.
REQ-037 Bench SHALL check: reset=1 together with reg_write to $7 -> $7=0, status=0, wr_count=0.
REQ-038 Bench SHALL check: preload wr_count to 0xFFFFFFFF via forced writes, one more write -> wr_count=0.
